// File: rtl/surf_dac_pkg.sv
// Shared definitions for the DAC update sequencer: state encoding,
// frame command code and array geometry.
package surf_dac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_GAP
    } state_t;

    localparam logic [3:0] FRAME_CMD  = 4'h3;
    localparam int         NCHIP      = 4;
    localparam int         NCH        = 8;
    localparam int         FRAME_BITS = 24;

endpackage

// File: rtl/dac_frame_shifter.sv
// Four-lane serialiser: loads one 24-bit frame per lane and clocks it out
// MSB first on a shared SCLK derived from clk_i.
module dac_frame_shifter
    import surf_dac_pkg::*;
#(
    parameter int SCLK_HALF  = 2,
    parameter int FRAME_BITS = 24
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [2:0]            chan_i,
    input  logic [NCHIP-1:0][15:0] word_i,
    output logic                  frame_done,
    output logic                  dac_sclk_o,
    output logic [NCHIP-1:0]      dac_sdi_o
);

    localparam int              HW    = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [HW-1:0]   HLAST = HW'(SCLK_HALF - 1);
    localparam logic [4:0]      BLAST = 5'(FRAME_BITS - 1);

    logic [NCHIP-1:0][FRAME_BITS-1:0] sr;
    logic [HW-1:0]                    hcnt;
    logic [4:0]                       bcnt;
    logic                             active;

    // NOTE: frame_done is combinational so the parent leaves SHIFT on the
    // same edge that drops SCLK after the last high phase, with no extra cycle.
    assign frame_done = active && dac_sclk_o && (hcnt == HLAST) && (bcnt == BLAST);

    // The lane pins are the shift-register MSBs, so they are registered too.
    always_comb begin
        dac_sdi_o = '0;
        for (int k = 0; k < NCHIP; k++) begin
            dac_sdi_o[k] = sr[k][FRAME_BITS-1];
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the values from before this edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr         <= '0;
            hcnt       <= '0;
            bcnt       <= '0;
            active     <= 1'b0;
            dac_sclk_o <= 1'b0;
        end else if (load_i) begin
            for (int k = 0; k < NCHIP; k++) begin
                sr[k] <= {FRAME_CMD, 1'b0, chan_i, word_i[k]};
            end
            hcnt       <= '0;
            bcnt       <= '0;
            active     <= 1'b1;
            dac_sclk_o <= 1'b0;
        end else if (active) begin
            if (hcnt == HLAST) begin
                hcnt <= '0;
                if (!dac_sclk_o) begin
                    dac_sclk_o <= 1'b1;
                end else begin
                    // Data advances only on the falling edge, giving a full
                    // half-period of setup and hold around each rising edge.
                    dac_sclk_o <= 1'b0;
                    for (int k = 0; k < NCHIP; k++) begin
                        sr[k] <= {sr[k][FRAME_BITS-2:0], 1'b0};
                    end
                    if (bcnt == BLAST) begin
                        active <= 1'b0;
                    end else begin
                        bcnt <= bcnt + 5'd1;
                    end
                end
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_update_sequencer.sv
// DAC setting store with registered readback, and the pass sequencer that
// walks all eight channels out to the four octal serial DACs.
module dac_update_sequencer
    import surf_dac_pkg::*;
#(
    parameter int SCLK_HALF  = 2,
    parameter int FRAME_BITS = 24
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_i,
    input  logic [4:0]  waddr_i,
    input  logic [15:0] wdat_i,
    input  logic [4:0]  raddr_i,
    output logic [15:0] rdat_o,
    input  logic        update_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        dac_sclk_o,
    output logic        dac_ncs_o,
    output logic [3:0]  dac_sdi_o
);

    localparam int            TW        = $clog2(2 * SCLK_HALF);
    localparam logic [TW-1:0] HOLD_LAST = TW'(SCLK_HALF - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(2 * SCLK_HALF - 1);
    localparam logic [2:0]    CH_LAST   = 3'(NCH - 1);

    logic [15:0]               mem [32];
    logic [NCHIP-1:0][15:0]    words;
    state_t                    state;
    logic [2:0]                chan;
    logic [TW-1:0]             tcnt;
    logic                      pending;
    logic                      frame_done;

    // NOTE: the store has no reset; it keeps its settings across a sequencer
    // reset and relies on configuration to start at zero.
    always_ff @(posedge clk_i) begin
        if (wr_i) begin
            mem[waddr_i] <= wdat_i;
        end
    end

    // Reads the pre-write contents when the same address is written this cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdat_o <= '0;
        end else begin
            rdat_o <= mem[raddr_i];
        end
    end

    always_comb begin
        words = '0;
        for (int k = 0; k < NCHIP; k++) begin
            words[k] = mem[{2'(k), chan}];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            chan      <= '0;
            tcnt      <= '0;
            pending   <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            dac_ncs_o <= 1'b1;
        end else begin
            done_o <= 1'b0;
            if (state != ST_IDLE && (update_i || wr_i)) begin
                pending <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (update_i || pending) begin
                        pending   <= 1'b0;
                        chan      <= '0;
                        busy_o    <= 1'b1;
                        dac_ncs_o <= 1'b0;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: state <= ST_SHIFT;
                ST_SHIFT: begin
                    if (frame_done) begin
                        tcnt  <= '0;
                        state <= ST_CS_HOLD;
                    end
                end
                ST_CS_HOLD: begin
                    if (tcnt == HOLD_LAST) begin
                        tcnt      <= '0;
                        dac_ncs_o <= 1'b1;
                        state     <= ST_GAP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tcnt != GAP_LAST) begin
                        tcnt <= tcnt + 1'b1;
                    end else begin
                        tcnt <= '0;
                        if (chan != CH_LAST) begin
                            chan      <= chan + 3'd1;
                            dac_ncs_o <= 1'b0;
                            state     <= ST_LOAD;
                        end else if (pending || update_i || wr_i) begin
                            // Chain straight into the next pass without an idle cycle.
                            pending   <= 1'b0;
                            chan      <= '0;
                            dac_ncs_o <= 1'b0;
                            state     <= ST_LOAD;
                        end else begin
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                            state  <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    dac_frame_shifter #(
        .SCLK_HALF  (SCLK_HALF),
        .FRAME_BITS (FRAME_BITS)
    ) u_shifter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (state == ST_LOAD),
        .chan_i     (chan),
        .word_i     (words),
        .frame_done (frame_done),
        .dac_sclk_o (dac_sclk_o),
        .dac_sdi_o  (dac_sdi_o)
    );

endmodule

// File: tb/tb_dac_update_sequencer.sv
// Directed bench for dac_update_sequencer: pass length, frame contents,
// readback, sticky passes, mid-frame reset and serial pin timing.
module tb_dac_update_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0;
    logic        update = 1'b0;
    logic [4:0]  waddr = '0;
    logic [4:0]  raddr = '0;
    logic [15:0] wdat = '0;
    logic [15:0] rdat;
    logic        busy, done, dac_sclk, dac_ncs;
    logic [3:0]  dac_sdi;

    int n_cmp = 0;
    int n_bad = 0;

    dac_update_sequencer #(.SCLK_HALF(2)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_i       (wr),
        .waddr_i    (waddr),
        .wdat_i     (wdat),
        .raddr_i    (raddr),
        .rdat_o     (rdat),
        .update_i   (update),
        .busy_o     (busy),
        .done_o     (done),
        .dac_sclk_o (dac_sclk),
        .dac_ncs_o  (dac_ncs),
        .dac_sdi_o  (dac_sdi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][23:0] lanes;
        int               edges;
    } frame_t;

    frame_t      frames[$];
    int          viol = 0;
    bit          mon_hold = 1'b1;
    logic [15:0] m_old [32];
    logic [15:0] m_new [32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pin monitor: captures frames and counts serial timing violations.
    initial begin
        int               since_change = 100;
        int               since_rise = 100;
        int               gap_cnt = 0;
        int               edges = 0;
        bit               seen_frame = 1'b0;
        logic [3:0][23:0] lanes = '0;
        logic             sclk_q = 1'b0;
        logic             ncs_q = 1'b1;
        logic [3:0]       sdi_q = '0;
        forever begin
            @(negedge clk);
            since_change++;
            since_rise++;
            if (mon_hold) begin
                edges = 0;
                lanes = '0;
                seen_frame = 1'b0;
                gap_cnt = 0;
            end else begin
                if (dac_sdi != sdi_q) begin
                    if (dac_sclk) viol++;
                    if (since_rise < 2) viol++;
                    since_change = 0;
                end
                if (dac_sclk && !sclk_q) begin
                    if (since_change < 2) viol++;
                    if (dac_ncs) viol++;
                    since_rise = 0;
                    edges++;
                    for (int k = 0; k < 4; k++) lanes[k] = {lanes[k][22:0], dac_sdi[k]};
                end
                if (dac_ncs && dac_sclk) viol++;
                if (!dac_ncs && ncs_q) begin
                    if (seen_frame && gap_cnt < 4) viol++;
                    edges = 0;
                    lanes = '0;
                end
                if (dac_ncs && !ncs_q) begin
                    frames.push_back('{lanes: lanes, edges: edges});
                    seen_frame = 1'b1;
                    gap_cnt = 0;
                end
                if (dac_ncs) gap_cnt++;
            end
            sclk_q = dac_sclk;
            ncs_q = dac_ncs;
            sdi_q = dac_sdi;
        end
    end

    // Pulses update, optionally injects an update or write at busy cycle n,
    // then counts busy cycles until the pass sequence ends.
    task automatic run_pass(input string name, input int exp_cycles, input int upd_at,
                            input int wr_at, input logic [4:0] wa, input logic [15:0] wd);
        int n = 0;
        int done_seen = 0;
        @(negedge clk) update = 1'b1;
        @(negedge clk) update = 1'b0;
        while (busy === 1'b1 && n < 5000) begin
            n++;
            if (done) done_seen++;
            update = (n == upd_at);
            wr = (n == wr_at);
            if (n == wr_at) begin
                waddr = wa;
                wdat = wd;
            end
            @(negedge clk);
        end
        update = 1'b0;
        wr = 1'b0;
        check({name, "_busy_cycles"}, n, exp_cycles);
        check({name, "_done_while_busy"}, done_seen, 0);
        check({name, "_done_at_fall"}, done, 1);
        @(negedge clk);
        check({name, "_done_one_pulse"}, done, 0);
        check({name, "_busy_stays_low"}, busy, 0);
    endtask

    task automatic check_frames(input string name, input int fb, input int nf);
        int got_n = frames.size() - fb;
        check({name, "_frame_count"}, got_n, nf);
        for (int i = 0; i < nf && i < got_n; i++) begin
            int c = i % 8;
            check($sformatf("%s_f%0d_edges", name, i), frames[fb+i].edges, 24);
            for (int k = 0; k < 4; k++) begin
                logic [15:0] m = (i < 8) ? m_old[8*k+c] : m_new[8*k+c];
                logic [23:0] e = {8'h30 + 8'(c), m};
                check($sformatf("%s_f%0d_l%0d", name, i, k), frames[fb+i].lanes[k], e);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fb;
        int vb;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sclk", dac_sclk, 0);
        check("rst_ncs", dac_ncs, 1);
        check("rst_sdi", dac_sdi, 0);
        check("rst_rdat", rdat, 0);
        rst = 1'b0;
        @(negedge clk) mon_hold = 1'b0;

        // Full pass with mem[a] = 0x1000 + a.
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            wr = 1'b1;
            waddr = 5'(a);
            wdat = 16'h1000 + 16'(a);
            m_old[a] = 16'h1000 + 16'(a);
        end
        @(negedge clk) wr = 1'b0;
        m_new = m_old;
        repeat (2) @(negedge clk);
        check("idle_write_no_pass", busy, 0);
        fb = frames.size();
        vb = viol;
        run_pass("full", 824, -1, -1, '0, '0);
        check_frames("full", fb, 8);
        check("full_pin_timing", viol - vb, 0);

        // Readback: same-cycle read sees the old value, next cycle the new one.
        @(negedge clk);
        wr = 1'b1;
        waddr = 5'd5;
        wdat = 16'hABCD;
        raddr = 5'd5;
        @(negedge clk) wr = 1'b0;
        check("rb_same_cycle_old", rdat, 16'h1005);
        @(negedge clk);
        check("rb_new_value", rdat, 16'hABCD);
        raddr = 5'd31;
        @(negedge clk);
        check("rb_addr31", rdat, 16'h101F);
        check("rb_no_pass", busy, 0);
        m_old[5] = 16'hABCD;
        m_new[5] = 16'hABCD;

        // Second update during frame 4 chains a second pass.
        fb = frames.size();
        vb = viol;
        run_pass("upd_busy", 1648, 4 * 103 + 10, -1, '0, '0);
        check_frames("upd_busy", fb, 16);
        check("upd_busy_pin_timing", viol - vb, 0);

        // Write during frame 3: first pass keeps old mem[0], second carries 0x0FFF.
        m_new[0] = 16'h0FFF;
        fb = frames.size();
        vb = viol;
        run_pass("wr_busy", 1648, -1, 3 * 103 + 20, 5'd0, 16'h0FFF);
        check_frames("wr_busy", fb, 16);
        check("wr_busy_pin_timing", viol - vb, 0);
        m_old = m_new;

        // Reset at busy cycle 50 aborts the frame and drops pending work.
        @(negedge clk) update = 1'b1;
        @(negedge clk) update = 1'b0;
        repeat (49) @(negedge clk);
        mon_hold = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ncs", dac_ncs, 1);
        check("midrst_sclk", dac_sclk, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_sdi", dac_sdi, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_stays_idle", busy, 0);
        mon_hold = 1'b0;
        fb = frames.size();
        vb = viol;
        run_pass("after_rst", 824, -1, -1, '0, '0);
        check_frames("after_rst", fb, 8);
        check("after_rst_pin_timing", viol - vb, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
